// File: rtl/fft32_pkg.sv
// ---------------------------------------------------------------------------
// fft32_pkg
// Shared constants, types and helpers for the 32-point FFT output serializer.
//
// Contents:
//   FFT_POINTS / FFT_LOG2 / FFT_SAMPLE_BITS / FFT_HALF_BITS  frame geometry
//   bin_idx_t      5-bit bin number
//   bin_word_t     one complex bin word, {real, imag}
//   bank_count_t   number of occupied frame banks (0..2)
//   bitrev5        5-bit bit reversal used for bit-reversed read-out
//   re_of / im_of  slice the real / imaginary half out of a bin word
// ---------------------------------------------------------------------------
package fft32_pkg;

    localparam int FFT_POINTS      = 32;
    localparam int FFT_LOG2        = 5;
    localparam int FFT_SAMPLE_BITS = 32;
    localparam int FFT_HALF_BITS   = 16;

    typedef logic [FFT_LOG2-1:0]        bin_idx_t;
    typedef logic [FFT_SAMPLE_BITS-1:0] bin_word_t;
    typedef logic [FFT_HALF_BITS-1:0]   half_word_t;
    typedef logic [1:0]                 bank_count_t;

    // Mirror the five index bits: bit 0 becomes bit 4 and so on.
    function automatic bin_idx_t bitrev5(input bin_idx_t idx);
        bin_idx_t rev;
        rev = '0;
        for (int b = 0; b < FFT_LOG2; b++) begin
            rev[FFT_LOG2-1-b] = idx[b];
        end
        return rev;
    endfunction

    function automatic half_word_t re_of(input bin_word_t word);
        return word[FFT_SAMPLE_BITS-1:FFT_HALF_BITS];
    endfunction

    function automatic half_word_t im_of(input bin_word_t word);
        return word[FFT_HALF_BITS-1:0];
    endfunction

endpackage

// File: rtl/fft32_frame_bank.sv
// ---------------------------------------------------------------------------
// fft32_frame_bank
// One frame-wide register bank: all entries are loaded in parallel from a
// full frame, and a single entry is read combinationally by address.
// The stored words carry no reset; they are only meaningful once written.
//
// Ports:
//   clock     in   1                      rising-edge clock
//   wr_en     in   1                      load every entry from wr_frame
//   wr_frame  in   p_points*p_sampleBits  entry k at [k*p_sampleBits +: p_sampleBits]
//   rd_addr   in   FFT_LOG2               entry to present on rd_data
//   rd_data   out  p_sampleBits           stored word at rd_addr
// ---------------------------------------------------------------------------
module fft32_frame_bank
    import fft32_pkg::*;
#(
    parameter int p_sampleBits = FFT_SAMPLE_BITS,
    parameter int p_points     = FFT_POINTS
) (
    input  logic                             clock,
    input  logic                             wr_en,
    input  logic [p_points*p_sampleBits-1:0] wr_frame,
    input  logic [FFT_LOG2-1:0]              rd_addr,
    output logic [p_sampleBits-1:0]          rd_data
);

    logic [p_sampleBits-1:0] mem [p_points];

    // Whole-frame capture: every lane lands in its own entry on the same edge.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int k = 0; k < p_points; k++) begin
                mem[k] <= wr_frame[k*p_sampleBits +: p_sampleBits];
            end
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fft32_output_serializer.sv
// ---------------------------------------------------------------------------
// fft32_output_serializer
// Captures complete 32-bin FFT frames in parallel into a pair of ping-pong
// banks and streams them out one bin per cycle over a valid/ready handshake.
//
// Ports:
//   CLK           in   1                      rising-edge clock
//   RST           in   1                      synchronous active-high reset
//   i_frameValid  in   1                      i_frame carries a complete frame
//   o_frameReady  out  1                      a bank is free to take a frame
//   i_frame       in   p_points*p_sampleBits  lane k = bin k
//   o_valid       out  1                      o_data/o_index/o_last valid
//   i_ready       in   1                      consumer takes the current bin
//   o_data        out  p_sampleBits           current bin word {re, im}
//   o_index       out  5                      bin number of o_data
//   o_last        out  1                      final bin of the frame
//   o_overflow    out  1                      sticky: a frame was dropped
//
// Build option:
//   FFT32_SER_BITREV_EN  when defined, bins leave in bit-reversed order
//                        (0,16,8,24,...); o_index still names the true bin.
// ---------------------------------------------------------------------------
module fft32_output_serializer
    import fft32_pkg::*;
#(
    parameter int p_sampleBits = FFT_SAMPLE_BITS,
    parameter int p_points     = FFT_POINTS
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic                             i_frameValid,
    output logic                             o_frameReady,
    input  logic [p_points*p_sampleBits-1:0] i_frame,
    output logic                             o_valid,
    input  logic                             i_ready,
    output logic [p_sampleBits-1:0]          o_data,
    output logic [FFT_LOG2-1:0]              o_index,
    output logic                             o_last,
    output logic                             o_overflow
);

    logic        r_wrBank;
    logic        r_rdBank;
    bank_count_t r_full;
    bin_idx_t    r_idx;
    logic        r_ovf;

    logic        accept;
    logic        transfer;
    logic        release_bank;
    bin_idx_t    rd_addr;
    logic [p_sampleBits-1:0] rd_data0;
    logic [p_sampleBits-1:0] rd_data1;

    // Handshake decode. Ready looks only at registered occupancy, so a bank
    // released this cycle cannot be refilled until the next one.
    always_comb begin
        o_frameReady = (r_full != 2'd2);
        o_valid      = (r_full != 2'd0);
        accept       = i_frameValid & o_frameReady;
        transfer     = o_valid & i_ready;
        release_bank = transfer & (r_idx == bin_idx_t'(FFT_POINTS-1));
    end

    // Read address generation: natural order, or mirrored index bits when
    // feeding a consumer that expects bit-reversed input.
`ifdef FFT32_SER_BITREV_EN
    assign rd_addr = bitrev5(r_idx);
`else
    assign rd_addr = r_idx;
`endif

    // Ping-pong storage. Writes are suppressed during reset so a frame held
    // on the input while RST is high is never captured.
    fft32_frame_bank #(
        .p_sampleBits(p_sampleBits),
        .p_points    (p_points)
    ) u_bank0 (
        .clock   (CLK),
        .wr_en   (accept & ~RST & ~r_wrBank),
        .wr_frame(i_frame),
        .rd_addr (rd_addr),
        .rd_data (rd_data0)
    );

    fft32_frame_bank #(
        .p_sampleBits(p_sampleBits),
        .p_points    (p_points)
    ) u_bank1 (
        .clock   (CLK),
        .wr_en   (accept & ~RST & r_wrBank),
        .wr_frame(i_frame),
        .rd_addr (rd_addr),
        .rd_data (rd_data1)
    );

    // Output presentation. Everything is derived from registered state, so
    // while the consumer stalls the word, index and last flag cannot move.
    always_comb begin
        o_data     = '0;
        o_index    = '0;
        o_last     = 1'b0;
        o_overflow = r_ovf;
        if (o_valid) begin
            o_data  = r_rdBank ? rd_data1 : rd_data0;
            o_index = rd_addr;
            o_last  = (r_idx == bin_idx_t'(FFT_POINTS-1));
        end
    end

    // Control state: bank pointers, occupancy, read index and the sticky
    // overflow flag. Reset drops any buffered or partially sent frame.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wrBank <= 1'b0;
            r_rdBank <= 1'b0;
            r_full   <= 2'd0;
            r_idx    <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (accept) begin
                r_wrBank <= ~r_wrBank;
            end
            if (transfer) begin
                r_idx <= r_idx + bin_idx_t'(1);
            end
            if (release_bank) begin
                r_rdBank <= ~r_rdBank;
            end
            // Occupancy only moves when exactly one of accept/release fires.
            if (accept && !release_bank) begin
                r_full <= r_full + 2'd1;
            end else if (!accept && release_bank) begin
                r_full <= r_full - 2'd1;
            end
            if (i_frameValid && !o_frameReady) begin
                r_ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fft32_output_serializer.sv
// ---------------------------------------------------------------------------
// tb_fft32_output_serializer
// Directed bench for the FFT frame serializer: reset, single frame, random
// back-pressure, ping-pong with overflow, same-cycle accept/release and,
// when FFT32_SER_BITREV_EN is defined, bit-reversed read-out.
// ---------------------------------------------------------------------------
module tb_fft32_output_serializer;

    localparam int PTS   = 32;
    localparam int WBITS = 32;
    localparam int FBITS = PTS * WBITS;

    logic             CLK;
    logic             RST;
    logic             i_frameValid;
    logic             o_frameReady;
    logic [FBITS-1:0] i_frame;
    logic             o_valid;
    logic             i_ready;
    logic [WBITS-1:0] o_data;
    logic [4:0]       o_index;
    logic             o_last;
    logic             o_overflow;

    int checks;
    int errors;

    fft32_output_serializer dut (
        .CLK         (CLK),
        .RST         (RST),
        .i_frameValid(i_frameValid),
        .o_frameReady(o_frameReady),
        .i_frame     (i_frame),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_data      (o_data),
        .o_index     (o_index),
        .o_last      (o_last),
        .o_overflow  (o_overflow)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference word for bin b of a frame tagged with base: {base+b, -(base+b)}.
    function automatic logic [WBITS-1:0] expWord(input int base, input int bin);
        logic [15:0] re;
        re = 16'(base + bin);
        return {re, 16'(-(base + bin))};
    endfunction

    function automatic logic [FBITS-1:0] makeFrame(input int base);
        logic [FBITS-1:0] f;
        for (int k = 0; k < PTS; k++) f[k*WBITS +: WBITS] = expWord(base, k);
        return f;
    endfunction

    function automatic int revBits(input int v);
        int r;
        r = 0;
        for (int b = 0; b < 5; b++) if (v[b]) r = r | (1 << (4 - b));
        return r;
    endfunction

    // Bin emitted at stream position p.
    function automatic int expBin(input int p);
`ifdef FFT32_SER_BITREV_EN
        return revBits(p);
`else
        return p;
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic fv, input logic [FBITS-1:0] fr,
                                 input logic rdy);
        i_frameValid = fv;
        i_frame      = fr;
        i_ready      = rdy;
        #1;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Consume count bins starting at stream position first, one per cycle.
    task automatic streamFrame(input int base, input int first, input int count);
        for (int p = first; p < first + count; p++) begin
            checkOutput("stream_valid", 32'(o_valid), 32'd1);
            checkOutput("stream_index", 32'(o_index), 32'(expBin(p)));
            checkOutput("stream_data", o_data, expWord(base, expBin(p)));
            checkOutput("stream_last", 32'(o_last), 32'(p == PTS - 1));
            tick();
        end
    endtask

    initial begin
        int expPos;
        logic rdy;
        checks = 0;
        errors = 0;

        // Reset held three cycles with a frame offered the whole time.
        RST = 1'b1;
        applyStimulus(1'b1, makeFrame(7000), 1'b0);
        repeat (3) tick();
        checkOutput("rst_valid", 32'(o_valid), 32'd0);
        checkOutput("rst_ready", 32'(o_frameReady), 32'd1);
        checkOutput("rst_ovf", 32'(o_overflow), 32'd0);
        RST = 1'b0;
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("rst_nocap_valid", 32'(o_valid), 32'd0);
        checkOutput("rst_data", o_data, 32'd0);
        checkOutput("rst_index", 32'(o_index), 32'd0);
        checkOutput("rst_last", 32'(o_last), 32'd0);
        tick();
        checkOutput("rst_idle_valid", 32'(o_valid), 32'd0);

        // Single frame, lane k = {k, -k}, consumer always ready.
        $display("[TB] single frame");
        applyStimulus(1'b1, makeFrame(0), 1'b1);
        checkOutput("single_pre_valid", 32'(o_valid), 32'd0);
        tick();
        applyStimulus(1'b0, '0, 1'b1);
        streamFrame(0, 0, PTS);
        checkOutput("single_post_valid", 32'(o_valid), 32'd0);

        // Random back-pressure: each bin seen exactly once, held while stalled.
        $display("[TB] back-pressure");
        applyStimulus(1'b1, makeFrame(100), 1'b0);
        tick();
        expPos = 0;
        for (int c = 0; c < 400 && expPos < PTS; c++) begin
            rdy = 1'($urandom_range(0, 1));
            applyStimulus(1'b0, '0, rdy);
            checkOutput("bp_valid", 32'(o_valid), 32'd1);
            checkOutput("bp_index", 32'(o_index), 32'(expBin(expPos)));
            checkOutput("bp_data", o_data, expWord(100, expBin(expPos)));
            checkOutput("bp_last", 32'(o_last), 32'(expPos == PTS - 1));
            if (rdy) expPos++;
            tick();
        end
        checkOutput("bp_all_bins", 32'(expPos), 32'(PTS));
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("bp_post_valid", 32'(o_valid), 32'd0);

        // Ping-pong with overflow: A and B taken, C dropped, then A,B gapless.
        $display("[TB] ping-pong and overflow");
        applyStimulus(1'b1, makeFrame(1000), 1'b0);
        checkOutput("pp_ready_a", 32'(o_frameReady), 32'd1);
        tick();
        applyStimulus(1'b1, makeFrame(2000), 1'b0);
        checkOutput("pp_ready_b", 32'(o_frameReady), 32'd1);
        checkOutput("pp_valid_a", 32'(o_valid), 32'd1);
        checkOutput("pp_data_a0", o_data, expWord(1000, expBin(0)));
        tick();
        applyStimulus(1'b1, makeFrame(3000), 1'b0);
        checkOutput("pp_ready_c", 32'(o_frameReady), 32'd0);
        tick();
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("pp_ovf", 32'(o_overflow), 32'd1);
        checkOutput("pp_ready_full", 32'(o_frameReady), 32'd0);
        checkOutput("pp_stall_data", o_data, expWord(1000, expBin(0)));
        applyStimulus(1'b0, '0, 1'b1);
        streamFrame(1000, 0, PTS);
        streamFrame(2000, 0, PTS);
        checkOutput("pp_post_valid", 32'(o_valid), 32'd0);
        checkOutput("pp_ovf_sticky", 32'(o_overflow), 32'd1);
        checkOutput("pp_post_ready", 32'(o_frameReady), 32'd1);

        // New frame offered on the cycle bin 31 of the current one transfers.
        $display("[TB] simultaneous accept and release");
        applyStimulus(1'b1, makeFrame(4000), 1'b1);
        tick();
        applyStimulus(1'b0, '0, 1'b1);
        streamFrame(4000, 0, PTS - 1);
        applyStimulus(1'b1, makeFrame(5000), 1'b1);
        checkOutput("sim_ready", 32'(o_frameReady), 32'd1);
        checkOutput("sim_last", 32'(o_last), 32'd1);
        checkOutput("sim_data31", o_data, expWord(4000, expBin(PTS - 1)));
        tick();
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("sim_ready_after", 32'(o_frameReady), 32'd1);
        streamFrame(5000, 0, PTS);
        checkOutput("sim_post_valid", 32'(o_valid), 32'd0);

`ifdef FFT32_SER_BITREV_EN
        // Data equals bin number: order must be 0,16,8,24,... with index = data.
        begin
            logic [FBITS-1:0] f;
            int order [4];
            order = '{0, 16, 8, 24};
            $display("[TB] bit-reversed order");
            for (int k = 0; k < PTS; k++) f[k*WBITS +: WBITS] = 32'(k);
            applyStimulus(1'b1, f, 1'b1);
            tick();
            applyStimulus(1'b0, '0, 1'b1);
            for (int p = 0; p < PTS; p++) begin
                if (p < 4) checkOutput("rev_head", o_data, 32'(order[p]));
                checkOutput("rev_data", o_data, 32'(revBits(p)));
                checkOutput("rev_index", 32'(o_index), 32'(revBits(p)));
                tick();
            end
        end
`endif

        // Reset is the only thing that clears the overflow flag.
        RST = 1'b1;
        tick();
        RST = 1'b0;
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("final_ovf", 32'(o_overflow), 32'd0);
        checkOutput("final_valid", 32'(o_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
